// File: rtl/rob_commit_pkg.sv
// Shared constants and types for the ROB commit unit.
//  - Default widths for the ROB, register file, data path, PC and exception vector
//  - EXC_NONE: the all-zero exception vector, meaning "no exception"
//  - rob_state_e: commit FSM states (RUN = 0, FLUSH = 1)
package rob_commit_pkg;

    localparam int unsigned ROB_ADDR_WIDTH = 4;
    localparam int unsigned ROB_DEPTH      = 1 << ROB_ADDR_WIDTH;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned RF_ADDR_WIDTH  = 5;
    localparam int unsigned EXC_WIDTH      = 8;

    localparam logic [EXC_WIDTH-1:0] EXC_NONE = '0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rob_state_e;

endpackage : rob_commit_pkg

// File: rtl/rob_commit_head_ptr.sv
// ROB head pointer: wrapping counter with synchronous clear.
//  clk, rst  : clock, asynchronous active-high reset
//  i_clear   : reset the pointer to 0 at the next edge (wins over i_inc)
//  i_inc     : advance the pointer by one, wrapping at 2**W
//  o_ptr     : current head index (registered)
module rob_commit_head_ptr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    // Natural binary overflow gives the wrap from 2**W-1 back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule : rob_commit_head_ptr

// File: rtl/rob_commit.sv
// In-order retire/commit unit on the ROB read side.
// Each cycle it inspects the ROB head line. A done line either commits its
// GPR/LO writes to the regfile or, if it carries an exception, raises the
// exception to CP0 and flushes the ROB.
//  Inputs : clk, rst, rob_empty_in, stall_in, head_* fields of the ROB head line
//  Outputs: head_addr_out (head index), retire_out, reg_write_* / reg_write_lo_*
//           (regfile write), exc_* (CP0 exception), flush_out, commit_count_out
// Every output is registered; the head line read is combinational, so head_*
// inputs belong to head_addr_out in the same cycle.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int unsigned ROB_ADDR_WIDTH = rob_commit_pkg::ROB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = rob_commit_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = rob_commit_pkg::ADDR_WIDTH,
    parameter int unsigned RF_ADDR_WIDTH  = rob_commit_pkg::RF_ADDR_WIDTH,
    parameter int unsigned EXC_WIDTH      = rob_commit_pkg::EXC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rob_empty_in,
    input  logic                      stall_in,
    output logic [ROB_ADDR_WIDTH-1:0] head_addr_out,
    input  logic                      head_done_in,
    input  logic                      head_reg_write_add_in,
    input  logic                      head_reg_write_en_in,
    input  logic [RF_ADDR_WIDTH-1:0]  head_reg_write_addr_in,
    input  logic [DATA_WIDTH-1:0]     head_reg_write_data_in,
    input  logic                      head_reg_write_lo_en_in,
    input  logic [DATA_WIDTH-1:0]     head_reg_write_lo_data_in,
    input  logic [EXC_WIDTH-1:0]      head_exception_type_in,
    input  logic                      head_is_delayslot_in,
    input  logic [ADDR_WIDTH-1:0]     head_pc_in,
    output logic                      retire_out,
    output logic                      reg_write_en_out,
    output logic                      reg_write_add_out,
    output logic [RF_ADDR_WIDTH-1:0]  reg_write_addr_out,
    output logic [DATA_WIDTH-1:0]     reg_write_data_out,
    output logic                      reg_write_lo_en_out,
    output logic [DATA_WIDTH-1:0]     reg_write_lo_data_out,
    output logic                      exc_en_out,
    output logic [EXC_WIDTH-1:0]      exc_type_out,
    output logic [ADDR_WIDTH-1:0]     exc_epc_out,
    output logic                      exc_is_delayslot_out,
    output logic                      flush_out,
    output logic [31:0]               commit_count_out
);

    rob_state_e r_state;
    logic       w_fire;
    logic       w_exc;

    // Retire only from RUN, with a valid, written-back head and no back-pressure.
    assign w_fire = (r_state == ST_RUN) & ~rob_empty_in & head_done_in & ~stall_in;
    assign w_exc  = (head_exception_type_in != EXC_WIDTH'(EXC_NONE));

    rob_commit_head_ptr #(
        .W (ROB_ADDR_WIDTH)
    ) u_head_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_fire & w_exc),
        .i_inc   (w_fire & ~w_exc),
        .o_ptr   (head_addr_out)
    );

    // Commit FSM with registered outputs; strobes default low, data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state               <= ST_RUN;
            retire_out            <= 1'b0;
            reg_write_en_out      <= 1'b0;
            reg_write_add_out     <= 1'b0;
            reg_write_addr_out    <= '0;
            reg_write_data_out    <= '0;
            reg_write_lo_en_out   <= 1'b0;
            reg_write_lo_data_out <= '0;
            exc_en_out            <= 1'b0;
            exc_type_out          <= '0;
            exc_epc_out           <= '0;
            exc_is_delayslot_out  <= 1'b0;
            flush_out             <= 1'b0;
            commit_count_out      <= '0;
        end else begin
            retire_out          <= 1'b0;
            reg_write_en_out    <= 1'b0;
            reg_write_lo_en_out <= 1'b0;
            exc_en_out          <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_fire) begin
                        retire_out       <= 1'b1;
                        commit_count_out <= commit_count_out + 32'd1;
                        if (!w_exc) begin
                            reg_write_en_out      <= head_reg_write_en_in;
                            reg_write_add_out     <= head_reg_write_add_in;
                            reg_write_addr_out    <= head_reg_write_addr_in;
                            reg_write_data_out    <= head_reg_write_data_in;
                            reg_write_lo_en_out   <= head_reg_write_lo_en_in;
                            reg_write_lo_data_out <= head_reg_write_lo_data_in;
                        end else begin
                            // Excepting line: no architectural writes, EPC points at the branch for a delay slot.
                            exc_en_out           <= 1'b1;
                            exc_type_out         <= head_exception_type_in;
                            exc_epc_out          <= head_is_delayslot_in ?
                                                    head_pc_in - ADDR_WIDTH'(4) : head_pc_in;
                            exc_is_delayslot_out <= head_is_delayslot_in;
                            flush_out            <= 1'b1;
                            r_state              <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Hold flush until the ROB reports empty; always at least one cycle.
                    if (rob_empty_in) begin
                        flush_out <= 1'b0;
                        r_state   <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule : rob_commit

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios plus randomized
// traffic checked against a transaction-level retire model.
module tb_rob_commit;
    import rob_commit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rob_empty_in, stall_in, head_done_in;
    logic        head_reg_write_add_in, head_reg_write_en_in, head_reg_write_lo_en_in;
    logic [4:0]  head_reg_write_addr_in;
    logic [31:0] head_reg_write_data_in, head_reg_write_lo_data_in, head_pc_in;
    logic [7:0]  head_exception_type_in;
    logic        head_is_delayslot_in;
    logic [3:0]  head_addr_out;
    logic        retire_out, reg_write_en_out, reg_write_add_out, reg_write_lo_en_out;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] reg_write_data_out, reg_write_lo_data_out, exc_epc_out, commit_count_out;
    logic        exc_en_out, exc_is_delayslot_out, flush_out;
    logic [7:0]  exc_type_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what the commit unit should present after each edge.
    bit          m_flushing;
    int unsigned m_head, m_count;
    bit          e_retire, e_wen, e_add, e_loen, e_exc_en, e_bd;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_lodata, e_epc;
    logic [7:0]  e_type;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk                       (clk),
        .rst                       (rst),
        .rob_empty_in              (rob_empty_in),
        .stall_in                  (stall_in),
        .head_addr_out             (head_addr_out),
        .head_done_in              (head_done_in),
        .head_reg_write_add_in     (head_reg_write_add_in),
        .head_reg_write_en_in      (head_reg_write_en_in),
        .head_reg_write_addr_in    (head_reg_write_addr_in),
        .head_reg_write_data_in    (head_reg_write_data_in),
        .head_reg_write_lo_en_in   (head_reg_write_lo_en_in),
        .head_reg_write_lo_data_in (head_reg_write_lo_data_in),
        .head_exception_type_in    (head_exception_type_in),
        .head_is_delayslot_in      (head_is_delayslot_in),
        .head_pc_in                (head_pc_in),
        .retire_out                (retire_out),
        .reg_write_en_out          (reg_write_en_out),
        .reg_write_add_out         (reg_write_add_out),
        .reg_write_addr_out        (reg_write_addr_out),
        .reg_write_data_out        (reg_write_data_out),
        .reg_write_lo_en_out       (reg_write_lo_en_out),
        .reg_write_lo_data_out     (reg_write_lo_data_out),
        .exc_en_out                (exc_en_out),
        .exc_type_out              (exc_type_out),
        .exc_epc_out               (exc_epc_out),
        .exc_is_delayslot_out      (exc_is_delayslot_out),
        .flush_out                 (flush_out),
        .commit_count_out          (commit_count_out)
    );

    task automatic model_reset();
        m_flushing = 0; m_head = 0; m_count = 0;
        e_retire = 0; e_wen = 0; e_add = 0; e_loen = 0; e_exc_en = 0; e_bd = 0;
        e_waddr = '0; e_wdata = '0; e_lodata = '0; e_epc = '0; e_type = '0;
    endtask

    // One retire decision per cycle from the current head line.
    task automatic model_edge();
        e_retire = 0; e_wen = 0; e_loen = 0; e_exc_en = 0;
        if (m_flushing) begin
            if (rob_empty_in) m_flushing = 0;
        end else if (!rob_empty_in && head_done_in && !stall_in) begin
            e_retire = 1;
            m_count  = m_count + 1;
            if (head_exception_type_in == 8'h00) begin
                e_wen    = head_reg_write_en_in;
                e_add    = head_reg_write_add_in;
                e_waddr  = head_reg_write_addr_in;
                e_wdata  = head_reg_write_data_in;
                e_loen   = head_reg_write_lo_en_in;
                e_lodata = head_reg_write_lo_data_in;
                m_head   = (m_head + 1) % ROB_DEPTH;
            end else begin
                e_exc_en   = 1;
                e_type     = head_exception_type_in;
                e_bd       = head_is_delayslot_in;
                e_epc      = head_is_delayslot_in ? head_pc_in - 32'd4 : head_pc_in;
                m_flushing = 1;
                m_head     = 0;
            end
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input bit done, input bit en, input logic [4:0] addr,
                            input logic [31:0] data, input logic [7:0] exc,
                            input bit bd, input logic [31:0] pc);
        head_done_in = done; head_reg_write_en_in = en; head_reg_write_addr_in = addr;
        head_reg_write_data_in = data; head_exception_type_in = exc;
        head_is_delayslot_in = bd; head_pc_in = pc;
        head_reg_write_add_in = 1'b0; head_reg_write_lo_en_in = 1'b0;
        head_reg_write_lo_data_in = '0;
    endtask

    task automatic apply_reset_mid_cycle();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        rob_empty_in = 1'b1; stall_in = 1'b0; rst = 1'b0;
        set_head(0, 0, '0, '0, '0, 0, '0);
        apply_reset_mid_cycle();
        n_cmp++;
        if ({retire_out, reg_write_en_out, reg_write_add_out, reg_write_addr_out,
             reg_write_data_out, reg_write_lo_en_out, reg_write_lo_data_out,
             exc_en_out, exc_type_out, exc_epc_out, exc_is_delayslot_out,
             flush_out, commit_count_out} !== '0) begin
            n_err++; $display("FAIL reset_outputs: some output nonzero after rst");
        end
        n_cmp++;
        if (head_addr_out !== 4'd0) begin
            n_err++; $display("FAIL reset_head: got %0d want 0", head_addr_out);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_normal_commit();
        rob_empty_in = 1'b0;
        set_head(1, 1, 5'd5, 32'hDEADBEEF, 8'h00, 0, 32'h100);
        cycle();
        n_cmp++;
        if ({retire_out, reg_write_en_out, reg_write_addr_out, reg_write_data_out} !==
            {1'b1, 1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL commit_fields: ret=%0d en=%0d addr=%0d data=%h want 1 1 5 DEADBEEF",
                              retire_out, reg_write_en_out, reg_write_addr_out, reg_write_data_out);
        end
        n_cmp++;
        if (head_addr_out !== 4'd1 || commit_count_out !== 32'd1) begin
            n_err++; $display("FAIL commit_head: head=%0d cnt=%0d want 1 1", head_addr_out, commit_count_out);
        end
        head_done_in = 1'b0;
        cycle();
        n_cmp++;
        if (retire_out !== 1'b0 || reg_write_en_out !== 1'b0 || reg_write_data_out !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL commit_idle: ret=%0d en=%0d data=%h want 0 0 DEADBEEF",
                              retire_out, reg_write_en_out, reg_write_data_out);
        end
    endtask

    task automatic test_not_done_stall();
        set_head(0, 1, 5'd7, 32'h12345678, 8'h00, 0, 32'h200);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (retire_out !== 1'b0 || reg_write_en_out !== 1'b0 || head_addr_out !== 4'd1) begin
                n_err++; $display("FAIL not_done_%0d: ret=%0d en=%0d head=%0d want 0 0 1",
                                  i, retire_out, reg_write_en_out, head_addr_out);
            end
        end
        head_done_in = 1'b1;
        cycle();
        n_cmp++;
        if (retire_out !== 1'b1 || reg_write_data_out !== 32'h12345678 || head_addr_out !== 4'd2) begin
            n_err++; $display("FAIL late_done: ret=%0d data=%h head=%0d want 1 12345678 2",
                              retire_out, reg_write_data_out, head_addr_out);
        end
        stall_in = 1'b1;
        cycle();
        n_cmp++;
        if (retire_out !== 1'b0 || head_addr_out !== 4'd2 || commit_count_out !== 32'd2) begin
            n_err++; $display("FAIL stall: ret=%0d head=%0d cnt=%0d want 0 2 2",
                              retire_out, head_addr_out, commit_count_out);
        end
        stall_in = 1'b0; rob_empty_in = 1'b1;
        cycle();
        n_cmp++;
        if (retire_out !== 1'b0 || head_addr_out !== 4'd2) begin
            n_err++; $display("FAIL empty_mask: ret=%0d head=%0d want 0 2", retire_out, head_addr_out);
        end
        rob_empty_in = 1'b0; head_done_in = 1'b0;
    endtask

    task automatic test_exception();
        set_head(1, 1, 5'd9, 32'hCAFE0000, 8'h04, 1, 32'hBFC00104);
        cycle();
        n_cmp++;
        if ({exc_en_out, retire_out, exc_type_out, exc_epc_out, exc_is_delayslot_out} !==
            {1'b1, 1'b1, 8'h04, 32'hBFC00100, 1'b1}) begin
            n_err++; $display("FAIL exc_fields: en=%0d ret=%0d type=%h epc=%h bd=%0d want 1 1 04 BFC00100 1",
                              exc_en_out, retire_out, exc_type_out, exc_epc_out, exc_is_delayslot_out);
        end
        n_cmp++;
        if (reg_write_en_out !== 1'b0 || flush_out !== 1'b1 || head_addr_out !== 4'd0) begin
            n_err++; $display("FAIL exc_flush: wen=%0d flush=%0d head=%0d want 0 1 0",
                              reg_write_en_out, flush_out, head_addr_out);
        end
        // Done lines are ignored while flushing.
        set_head(1, 1, 5'd3, 32'h1, 8'h00, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (flush_out !== 1'b1 || retire_out !== 1'b0 || exc_en_out !== 1'b0) begin
                n_err++; $display("FAIL flush_hold_%0d: flush=%0d ret=%0d exc=%0d want 1 0 0",
                                  i, flush_out, retire_out, exc_en_out);
            end
        end
        rob_empty_in = 1'b1;
        cycle();
        n_cmp++;
        if (flush_out !== 1'b0) begin
            n_err++; $display("FAIL flush_exit: got %0d want 0", flush_out);
        end
        // Non-delay-slot exception, ROB empty right away: flush lasts exactly one cycle.
        rob_empty_in = 1'b0;
        set_head(1, 0, 5'd0, 32'h0, 8'h20, 0, 32'h80000040);
        cycle();
        n_cmp++;
        if (exc_epc_out !== 32'h80000040 || exc_is_delayslot_out !== 1'b0 || flush_out !== 1'b1) begin
            n_err++; $display("FAIL exc_nobd: epc=%h bd=%0d flush=%0d want 80000040 0 1",
                              exc_epc_out, exc_is_delayslot_out, flush_out);
        end
        rob_empty_in = 1'b1;
        cycle();
        n_cmp++;
        if (flush_out !== 1'b0) begin
            n_err++; $display("FAIL flush_min: got %0d want 0", flush_out);
        end
        // Reset in the middle of a flush.
        rob_empty_in = 1'b0;
        set_head(1, 0, 5'd0, 32'h0, 8'h01, 0, 32'h4);
        cycle();
        head_done_in = 1'b0;
        apply_reset_mid_cycle();
        n_cmp++;
        if (flush_out !== 1'b0 || head_addr_out !== 4'd0 || commit_count_out !== 32'd0) begin
            n_err++; $display("FAIL rst_in_flush: flush=%0d head=%0d cnt=%0d want 0 0 0",
                              flush_out, head_addr_out, commit_count_out);
        end
        @(posedge clk); #1 rst = 1'b0;
        set_head(1, 1, 5'd2, 32'h55, 8'h00, 0, 32'h8);
        cycle();
        n_cmp++;
        if (retire_out !== 1'b1 || reg_write_en_out !== 1'b1 || head_addr_out !== 4'd1) begin
            n_err++; $display("FAIL run_after_rst: ret=%0d wen=%0d head=%0d want 1 1 1",
                              retire_out, reg_write_en_out, head_addr_out);
        end
        head_done_in = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        logic [31:0] d;
        apply_reset_mid_cycle();
        @(posedge clk); #1 rst = 1'b0;
        rob_empty_in = 1'b0;
        for (int i = 0; i < 17; i++) begin
            d = $urandom;
            set_head(1, 1, 5'(i), d, 8'h00, 0, 32'(i * 4));
            cycle();
            n_cmp++;
            if (head_addr_out !== 4'((i + 1) % 16) || retire_out !== 1'b1 || reg_write_data_out !== d) begin
                n_err++; $display("FAIL wrap_%0d: head=%0d ret=%0d data=%h want %0d 1 %h",
                                  i, head_addr_out, retire_out, reg_write_data_out, (i + 1) % 16, d);
            end
        end
        n_cmp++;
        if (commit_count_out !== 32'd17) begin
            n_err++; $display("FAIL wrap_count: got %0d want 17", commit_count_out);
        end
        head_done_in = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rob_empty_in              = ($urandom_range(0, 4) == 0);
            stall_in                  = ($urandom_range(0, 5) == 0);
            head_done_in              = ($urandom_range(0, 3) != 0);
            head_reg_write_en_in      = 1'($urandom);
            head_reg_write_add_in     = 1'($urandom);
            head_reg_write_addr_in    = 5'($urandom);
            head_reg_write_data_in    = $urandom;
            head_reg_write_lo_en_in   = 1'($urandom);
            head_reg_write_lo_data_in = $urandom;
            head_exception_type_in    = ($urandom_range(0, 11) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            head_is_delayslot_in      = 1'($urandom);
            head_pc_in                = $urandom;
            cycle();
            n_cmp++;
            if ({retire_out, reg_write_en_out, reg_write_lo_en_out, exc_en_out, flush_out} !==
                {e_retire, e_wen, e_loen, e_exc_en, m_flushing}) begin
                n_err++; $display("FAIL rnd_strobes_%0d: got ret/wen/lo/exc/fl=%b want %b", i,
                                  {retire_out, reg_write_en_out, reg_write_lo_en_out, exc_en_out, flush_out},
                                  {e_retire, e_wen, e_loen, e_exc_en, m_flushing});
            end
            n_cmp++;
            if ({reg_write_add_out, reg_write_addr_out, reg_write_data_out, reg_write_lo_data_out} !==
                {e_add, e_waddr, e_wdata, e_lodata}) begin
                n_err++; $display("FAIL rnd_wdata_%0d: got %0d %0d %h %h want %0d %0d %h %h", i,
                                  reg_write_add_out, reg_write_addr_out, reg_write_data_out, reg_write_lo_data_out,
                                  e_add, e_waddr, e_wdata, e_lodata);
            end
            n_cmp++;
            if ({exc_type_out, exc_epc_out, exc_is_delayslot_out} !== {e_type, e_epc, e_bd}) begin
                n_err++; $display("FAIL rnd_exc_%0d: got %h %h %0d want %h %h %0d", i,
                                  exc_type_out, exc_epc_out, exc_is_delayslot_out, e_type, e_epc, e_bd);
            end
            n_cmp++;
            if (head_addr_out !== 4'(m_head) || commit_count_out !== m_count) begin
                n_err++; $display("FAIL rnd_ptr_%0d: head=%0d cnt=%0d want %0d %0d", i,
                                  head_addr_out, commit_count_out, m_head, m_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_commit();
        test_not_done_stall();
        test_exception();
        test_back_to_back_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rob_commit
